rob_retire: RTL and testbench

- In-order retirement buffer (reorder buffer) of the out-of-order core.
- Dispatch allocates an entry per renamed instruction. Execution writeback marks entries complete with the result.
- Retires up to 2 oldest completed entries per cycle by driving the architectural register file write interface (write_addr/write_data/old_addr pairs, shared write_en).

---
 rtl/rob_retire.sv | 170 +++++++++++++++++
 tb/tb_rob_retire.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at tail, marks entries complete on writeback,
// and retires up to two oldest completed entries per cycle into the register file.
module rob_retire #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX   = 4,
  parameter int AR_SIZE   = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               alloc_valid,
  input  logic [AR_SIZE-1:0] alloc_pr,
  input  logic [5:0]         alloc_ar,
  output logic [ROB_IDX-1:0] alloc_idx,
  output logic               rob_full,
  input  logic               wb_valid1,
  input  logic [ROB_IDX-1:0] wb_idx1,
  input  logic [31:0]        wb_data1,
  input  logic               wb_valid2,
  input  logic [ROB_IDX-1:0] wb_idx2,
  input  logic [31:0]        wb_data2,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [31:0]        write_data1,
  output logic [31:0]        write_data2,
  output logic [5:0]         old_addr1,
  output logic [5:0]         old_addr2,
  output logic               write_en,
  output logic [ROB_IDX:0]   rob_count
);

  localparam int unsigned          FULL_INT = ROB_DEPTH;
  localparam logic [ROB_IDX:0]     FULL_CNT = FULL_INT[ROB_IDX:0];
  localparam logic [ROB_IDX-1:0]   IDX_ONE  = {{(ROB_IDX-1){1'b0}}, 1'b1};

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [AR_SIZE-1:0]   pr_q [ROB_DEPTH];
  logic [AR_SIZE-1:0]   pr_d [ROB_DEPTH];
  logic [5:0]           ar_q [ROB_DEPTH];
  logic [5:0]           ar_d [ROB_DEPTH];
  logic [31:0]          data_q [ROB_DEPTH];
  logic [31:0]          data_d [ROB_DEPTH];

  logic [ROB_IDX-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IDX:0]   count_q, count_d;

  logic               write_en_q, write_en_d;
  logic [AR_SIZE-1:0] write_addr1_q, write_addr1_d, write_addr2_q, write_addr2_d;
  logic [31:0]        write_data1_q, write_data1_d, write_data2_q, write_data2_d;
  logic [5:0]         old_addr1_q, old_addr1_d, old_addr2_q, old_addr2_d;

  logic [ROB_IDX-1:0] head1;
  logic               r0, r1, alloc_ok;
  logic [1:0]         nret;

  assign head1    = head_q + IDX_ONE;
  assign r0       = valid_q[head_q] && done_q[head_q];
  assign r1       = r0 && valid_q[head1] && done_q[head1];
  assign nret     = {1'b0, r0} + {1'b0, r1};
  assign rob_full = (count_q == FULL_CNT);
  assign alloc_ok = alloc_valid && !rob_full;

  // Writeback runs before the retire clear and allocation so that those take priority.
  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    pr_d          = pr_q;
    ar_d          = ar_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    write_en_d    = 1'b0;
    write_addr1_d = '0;
    write_addr2_d = '0;
    write_data1_d = '0;
    write_data2_d = '0;
    old_addr1_d   = '0;
    old_addr2_d   = '0;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_valid1 && valid_q[wb_idx1]) begin
        done_d[wb_idx1] = 1'b1;
        data_d[wb_idx1] = wb_data1;
      end
      if (wb_valid2 && valid_q[wb_idx2]) begin
        done_d[wb_idx2] = 1'b1;
        data_d[wb_idx2] = wb_data2;
      end
      if (r0) begin
        write_en_d      = 1'b1;
        write_addr1_d   = pr_q[head_q];
        write_data1_d   = data_q[head_q];
        old_addr1_d     = ar_q[head_q];
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
      end
      if (r1) begin
        write_addr2_d  = pr_q[head1];
        write_data2_d  = data_q[head1];
        old_addr2_d    = ar_q[head1];
        valid_d[head1] = 1'b0;
        done_d[head1]  = 1'b0;
      end
      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        pr_d[tail_q]    = alloc_pr;
        ar_d[tail_q]    = alloc_ar;
        tail_d          = tail_q + IDX_ONE;
      end
      head_d  = head_q + {{(ROB_IDX-2){1'b0}}, nret};
      count_d = count_q + {{ROB_IDX{1'b0}}, alloc_ok} - {{(ROB_IDX-1){1'b0}}, nret};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      write_en_q    <= 1'b0;
      write_addr1_q <= '0;
      write_addr2_q <= '0;
      write_data1_q <= '0;
      write_data2_q <= '0;
      old_addr1_q   <= '0;
      old_addr2_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      done_q        <= done_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      write_en_q    <= write_en_d;
      write_addr1_q <= write_addr1_d;
      write_addr2_q <= write_addr2_d;
      write_data1_q <= write_data1_d;
      write_data2_q <= write_data2_d;
      old_addr1_q   <= old_addr1_d;
      old_addr2_q   <= old_addr2_d;
    end
  end

  // Payload storage is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    pr_q   <= pr_d;
    ar_q   <= ar_d;
    data_q <= data_d;
  end

  assign alloc_idx   = tail_q;
  assign rob_count   = count_q;
  assign write_en    = write_en_q;
  assign write_addr1 = write_addr1_q;
  assign write_addr2 = write_addr2_q;
  assign write_data1 = write_data1_q;
  assign write_data2 = write_data2_q;
  assign old_addr1   = old_addr1_q;
  assign old_addr2   = old_addr2_q;

endmodule

// File: tb/tb_rob_retire.sv
// Scoreboard bench for rob_retire: directed stimulus pushes expected retirement
// groups; a negedge monitor pops and compares whenever write_en is presented.
module tb_rob_retire;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        alloc_valid;
  logic [5:0]  alloc_pr;
  logic [5:0]  alloc_ar;
  logic [3:0]  alloc_idx;
  logic        rob_full;
  logic        wb_valid1, wb_valid2;
  logic [3:0]  wb_idx1, wb_idx2;
  logic [31:0] wb_data1, wb_data2;
  logic [5:0]  write_addr1, write_addr2;
  logic [31:0] write_data1, write_data2;
  logic [5:0]  old_addr1, old_addr2;
  logic        write_en;
  logic [4:0]  rob_count;

  typedef struct {
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [5:0]  o1;
    logic [5:0]  a2;
    logic [31:0] d2;
    logic [5:0]  o2;
  } ret_t;

  ret_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rob_retire #(.ROB_DEPTH(16), .ROB_IDX(4), .AR_SIZE(6)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_pr(alloc_pr), .alloc_ar(alloc_ar),
    .alloc_idx(alloc_idx), .rob_full(rob_full),
    .wb_valid1(wb_valid1), .wb_idx1(wb_idx1), .wb_data1(wb_data1),
    .wb_valid2(wb_valid2), .wb_idx2(wb_idx2), .wb_data2(wb_data2),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_data1(write_data1), .write_data2(write_data2),
    .old_addr1(old_addr1), .old_addr2(old_addr2),
    .write_en(write_en), .rob_count(rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExpected(input logic [5:0] a1, input logic [31:0] d1, input logic [5:0] o1,
                              input logic [5:0] a2, input logic [31:0] d2, input logic [5:0] o2);
    ret_t e;
    e.a1 = a1; e.d1 = d1; e.o1 = o1;
    e.a2 = a2; e.d2 = d2; e.o2 = o2;
    sb.push_back(e);
  endtask

  // One clock of stimulus, then inputs return to idle.
  task automatic applyStimulus(input logic av, input logic [5:0] pr, input logic [5:0] ar,
                               input logic w1v, input logic [3:0] w1i, input logic [31:0] w1d,
                               input logic w2v, input logic [3:0] w2i, input logic [31:0] w2d,
                               input logic fl);
    alloc_valid = av; alloc_pr = pr; alloc_ar = ar;
    wb_valid1 = w1v; wb_idx1 = w1i; wb_data1 = w1d;
    wb_valid2 = w2v; wb_idx2 = w2i; wb_data2 = w2d;
    flush = fl;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0; wb_valid1 = 1'b0; wb_valid2 = 1'b0; flush = 1'b0;
  endtask

  task automatic doAlloc(input logic [5:0] pr, input logic [5:0] ar);
    applyStimulus(1'b1, pr, ar, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic doWb(input logic [3:0] idx, input logic [31:0] d);
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, idx, d, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  // Monitor: every retirement group must match the oldest expected one.
  always @(negedge clk) begin
    ret_t e;
    if (rstn) begin
      checks++;
      if (rob_count > 5'd16) begin
        errors++;
        $display("[TB] FAIL count_bound actual=%0d required<=16", rob_count);
      end
      if (write_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write_en actual addr1=%0d required no retirement", write_addr1);
        end else begin
          e = sb.pop_front();
          checkOutput("write_addr1", {26'd0, write_addr1}, {26'd0, e.a1});
          checkOutput("write_data1", write_data1, e.d1);
          checkOutput("old_addr1", {26'd0, old_addr1}, {26'd0, e.o1});
          checkOutput("write_addr2", {26'd0, write_addr2}, {26'd0, e.a2});
          checkOutput("write_data2", write_data2, e.d2);
          checkOutput("old_addr2", {26'd0, old_addr2}, {26'd0, e.o2});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  tail;
    logic [5:0]  p1, p2, a1, a2;
    logic [31:0] d1, d2;
    int          waited;

    rstn = 1'b0; flush = 1'b0;
    alloc_valid = 1'b1; alloc_pr = 6'd9; alloc_ar = 6'd1;
    wb_valid1 = 1'b0; wb_idx1 = '0; wb_data1 = '0;
    wb_valid2 = 1'b0; wb_idx2 = '0; wb_data2 = '0;

    // Reset held with allocation requested
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_write_en", {31'd0, write_en}, 32'd0);
    checkOutput("rst_rob_count", {27'd0, rob_count}, 32'd0);
    checkOutput("rst_alloc_idx", {28'd0, alloc_idx}, 32'd0);
    checkOutput("rst_rob_full", {31'd0, rob_full}, 32'd0);
    checkOutput("rst_write_addr1", {26'd0, write_addr1}, 32'd0);
    checkOutput("rst_write_data1", write_data1, 32'd0);
    checkOutput("rst_old_addr2", {26'd0, old_addr2}, 32'd0);
    alloc_valid = 1'b0;
    rstn = 1'b1;
    doIdle();

    // Single retire at idx0
    doAlloc(6'd5, 6'd3);
    checkOutput("single_alloc_idx", {28'd0, alloc_idx}, 32'd1);
    checkOutput("single_count", {27'd0, rob_count}, 32'd1);
    pushExpected(6'd5, 32'h2A, 6'd3, 6'd0, 32'd0, 6'd0);
    doWb(4'd0, 32'h2A);
    checkOutput("single_no_early_we", {31'd0, write_en}, 32'd0);
    doIdle();
    checkOutput("single_we", {31'd0, write_en}, 32'd1);
    checkOutput("single_count_after", {27'd0, rob_count}, 32'd0);
    doIdle();

    // Dual retire with out-of-order completion at idx 1/2/3
    doAlloc(6'd7, 6'd1);
    doAlloc(6'd8, 6'd2);
    doAlloc(6'd9, 6'd3);
    doWb(4'd3, 32'h33);
    doWb(4'd2, 32'h22);
    doIdle();
    checkOutput("dual_blocked_we", {31'd0, write_en}, 32'd0);
    checkOutput("dual_blocked_count", {27'd0, rob_count}, 32'd3);
    pushExpected(6'd7, 32'h11, 6'd1, 6'd8, 32'h22, 6'd2);
    pushExpected(6'd9, 32'h33, 6'd3, 6'd0, 32'd0, 6'd0);
    doWb(4'd1, 32'h11);
    doIdle();
    checkOutput("dual_count_mid", {27'd0, rob_count}, 32'd1);
    doIdle();
    doIdle();
    checkOutput("dual_count_end", {27'd0, rob_count}, 32'd0);
    checkOutput("dual_alloc_idx", {28'd0, alloc_idx}, 32'd4);

    // Fill from idx4, wrapping the tail back to 4
    for (int i = 0; i < 16; i++) doAlloc(6'(10 + i), 6'(i));
    checkOutput("full_flag", {31'd0, rob_full}, 32'd1);
    checkOutput("full_count", {27'd0, rob_count}, 32'd16);
    checkOutput("full_alloc_idx", {28'd0, alloc_idx}, 32'd4);
    doAlloc(6'd63, 6'd63);
    checkOutput("full_ignored_idx", {28'd0, alloc_idx}, 32'd4);
    checkOutput("full_ignored_count", {27'd0, rob_count}, 32'd16);
    pushExpected(6'd10, 32'h1234, 6'd0, 6'd0, 32'd0, 6'd0);
    applyStimulus(1'b1, 6'd62, 6'd62, 1'b1, 4'd4, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0);
    // Retiring edge: the alloc still sees the registered full count
    doAlloc(6'd61, 6'd61);
    checkOutput("full_retire_count", {27'd0, rob_count}, 32'd15);
    checkOutput("full_retire_idx", {28'd0, alloc_idx}, 32'd4);
    checkOutput("full_cleared", {31'd0, rob_full}, 32'd0);

    // Flush with concurrent alloc and writeback, all discarded
    applyStimulus(1'b1, 6'd33, 6'd33, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0, 1'b1);
    checkOutput("flush1_we", {31'd0, write_en}, 32'd0);
    checkOutput("flush1_count", {27'd0, rob_count}, 32'd0);
    checkOutput("flush1_alloc_idx", {28'd0, alloc_idx}, 32'd0);
    doIdle();

    // Wrap-around: 20 pairs = 40 entries, dual writebacks, tail wraps twice
    tail = 4'd0;
    for (int k = 0; k < 20; k++) begin
      p1 = (k == 5) ? 6'd0 : 6'(((2 * k) % 62) + 1);
      p2 = 6'(((2 * k + 1) % 62) + 1);
      a1 = 6'((2 * k) % 64);
      a2 = 6'((2 * k + 1) % 64);
      d1 = 32'hA000_0000 + 32'(2 * k);
      d2 = 32'hA000_0000 + 32'(2 * k + 1);
      checkOutput("wrap_alloc_idx", {28'd0, alloc_idx}, {28'd0, tail});
      doAlloc(p1, a1);
      doAlloc(p2, a2);
      checkOutput("wrap_count2", {27'd0, rob_count}, 32'd2);
      pushExpected(p1, d1, a1, p2, d2, a2);
      if (k % 2 == 0)
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, tail, d1, 1'b1, tail + 4'd1, d2, 1'b0);
      else
        applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, tail + 4'd1, d2, 1'b1, tail, d1, 1'b0);
      doIdle();
      checkOutput("wrap_count0", {27'd0, rob_count}, 32'd0);
      tail = tail + 4'd2;
    end
    doIdle();

    // Flush mid-operation: 5 entries at idx 8..12, idx 9/10 done, head not done
    for (int i = 0; i < 5; i++) doAlloc(6'(40 + i), 6'(20 + i));
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA, 1'b0);
    doIdle();
    checkOutput("pre_flush_we", {31'd0, write_en}, 32'd0);
    checkOutput("pre_flush_count", {27'd0, rob_count}, 32'd5);
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    checkOutput("flush2_we", {31'd0, write_en}, 32'd0);
    checkOutput("flush2_count", {27'd0, rob_count}, 32'd0);
    checkOutput("flush2_alloc_idx", {28'd0, alloc_idx}, 32'd0);
    doWb(4'd9, 32'hDEAD);
    doIdle();
    doIdle();
    checkOutput("stale_wb_count", {27'd0, rob_count}, 32'd0);
    doAlloc(6'd50, 6'd7);
    pushExpected(6'd50, 32'hBEEF, 6'd7, 6'd0, 32'd0, 6'd0);
    doWb(4'd0, 32'hBEEF);
    doIdle();
    doIdle();
    checkOutput("final_count", {27'd0, rob_count}, 32'd0);

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      doIdle();
      waited++;
    end
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
